// File: rtl/bcd_serial_adder.sv
// Packed-BCD adder that runs one shared "+6 above 9" digit stage over the
// operand, least-significant digit first, with a start/busy/done handshake.

module bcd_digit_add (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] raw;

    // (raw + 6) mod 16 only depends on raw[3:0], so the low nibble is enough
    always_comb begin
        raw = {1'b0, x} + {1'b0, y} + {4'b0, ci};
        co  = (raw > 5'd9);
        s   = co ? raw[3:0] + 4'd6 : raw[3:0];
    end
endmodule

module bcd_digit_chk (
    input  logic [3:0] d,
    output logic       bad
);
    assign bad = (d > 4'd9);
endmodule

module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

    typedef enum logic {IDLE, ADD} state_t;

    state_t                  state;
    logic [DIGITS-1:0][3:0]  opa, opb, sum_r;
    logic [IDXW-1:0]         idx;
    logic                    c;
    logic [DIGITS-1:0]       bad_a, bad_b;
    logic [3:0]              dsum;
    logic                    dco;

    // Validity is judged on the live inputs so err is ready at the accepting edge
    for (genvar g = 0; g < DIGITS; g++) begin : g_chk
        bcd_digit_chk u_chk_a (.d(a[4*g +: 4]), .bad(bad_a[g]));
        bcd_digit_chk u_chk_b (.d(b[4*g +: 4]), .bad(bad_b[g]));
    end

    bcd_digit_add u_add (
        .x  (opa[idx]),
        .y  (opb[idx]),
        .ci (c),
        .s  (dsum),
        .co (dco)
    );

    assign sum = sum_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            sum_r <= '0;
            idx   <= '0;
            c     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        c     <= cin;
                        sum_r <= '0;
                        cout  <= 1'b0;
                        err   <= |{bad_a, bad_b};
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum_r[idx] <= dsum;
                    c          <= dco;
                    if (idx == LAST) begin
                        cout  <= dco;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): vector table,
// randomized ops against a digit-arithmetic model, and handshake corner cases.

module tb_bcd_serial_adder;
    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, err;
    logic [15:0] sum;

    int checks = 0;
    int errors = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] esum;
        logic        ecout;
        logic        eerr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Digit-by-digit decimal addition on plain integers
    function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic ci,
                                  output logic [15:0] s, output logic co, output logic er);
        int carry = ci;
        int acc = 0;
        er = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            int xa = (x >> (4*i)) % 16;
            int yb = (y >> (4*i)) % 16;
            int t = xa + yb + carry;
            if (xa > 9 || yb > 9) er = 1'b1;
            if (t > 9) begin
                t = (t + 6) % 16;
                carry = 1;
            end else begin
                carry = 0;
            end
            acc += t << (4*i);
        end
        s  = acc[15:0];
        co = carry[0];
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Launches one op; returns the result seen on the done cycle and the
    // number of edges from the accepting edge to done.
    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                         output logic [15:0] s, output logic co, output logic er,
                         output int lat, output logic busy0);
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = sum; co = cout; er = err;
    endtask

    vec_t vecs[6];

    initial begin
        logic [15:0] s, es;
        logic co, er, eco, eer, b0;
        int lat, npulse, last_done;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[3] = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);
        chk("reset_err", err, 0);

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, er, lat, b0);
            chk($sformatf("vec%0d_busy", i), b0, 1);
            chk($sformatf("vec%0d_lat", i), lat, DIGITS);
            chk($sformatf("vec%0d_sum", i), s, vecs[i].esum);
            chk($sformatf("vec%0d_cout", i), co, vecs[i].ecout);
            chk($sformatf("vec%0d_err", i), er, vecs[i].eerr);
        end

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic rc;
            if (i % 4 == 3) begin
                ra = 16'($urandom); rb = 16'($urandom);
            end else begin
                ra = to_bcd(int'($urandom_range(0, 9999)));
                rb = to_bcd(int'($urandom_range(0, 9999)));
            end
            rc = 1'($urandom);
            model(ra, rb, rc, es, eco, eer);
            do_op(ra, rb, rc, s, co, er, lat, b0);
            chk($sformatf("rnd%0d_sum", i), s, es);
            chk($sformatf("rnd%0d_cout", i), co, eco);
            chk($sformatf("rnd%0d_err", i), er, eer);
            chk($sformatf("rnd%0d_lat", i), lat, DIGITS);
        end

        // start and operand changes while busy must not disturb the op
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h9999; b = 16'h9999; cin = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        npulse = 0; s = '1;
        for (int i = 0; i < 10; i++) begin
            if (done) begin npulse++; s = sum; end
            @(negedge clk);
        end
        chk("busy_ignore_pulses", npulse, 1);
        chk("busy_ignore_sum", s, 16'h6912);

        // reset in the middle of an operation
        @(negedge clk);
        a = 16'h00A0; b = 16'h0000; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_err_before", err, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_err", err, 0);
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) npulse++;
            @(negedge clk);
        end
        chk("abort_no_done", npulse, 0);
        do_op(16'h0999, 16'h0001, 1'b0, s, co, er, lat, b0);
        chk("after_abort_sum", s, 16'h1000);
        chk("after_abort_lat", lat, DIGITS);

        // start held high: one result every DIGITS+1 cycles
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        last_done = -1;
        npulse = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                npulse++;
                chk($sformatf("held_sum%0d", npulse), sum, 16'h6912);
                if (last_done >= 0) chk($sformatf("held_gap%0d", npulse), i - last_done, DIGITS + 1);
                last_done = i;
            end
        end
        start = 1'b0;
        chk("held_pulses", npulse, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
